// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter with start/stop framing.
// A word captured on en_i while ready_o is high goes out LSB first, framed by a
// low start bit and a high stop bit. Each serial bit lasts DIV clock cycles.
// All outputs come straight from registers.
module serial_tx #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV   = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             ready_o,
    output logic             sout_o,
    output logic             sact_o,
    output logic             done_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
    localparam logic [DivW-1:0] LastDiv = DivW'(DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DivW-1:0]  div_cnt_q, div_cnt_d;
    logic             sout_q, sout_d;
    logic             sact_q, sact_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             bit_end;

    // Last cycle of the current serial bit period.
    assign bit_end = (div_cnt_q == LastDiv);

    // Next-state logic; output registers are computed one cycle ahead so the
    // serial line changes on the same edge as the state.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        sout_d    = sout_q;
        sact_d    = sact_q;
        ready_d   = ready_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (en_i) begin
                    shift_d   = d_i;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    state_d   = StStart;
                    sout_d    = 1'b0;
                    sact_d    = 1'b1;
                    ready_d   = 1'b0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = StData;
                    sout_d    = shift_q[0];
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    div_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LastBit) begin
                        state_d = StStop;
                        sout_d  = 1'b1;
                    end else begin
                        // Present the next data bit from the shifted word.
                        sout_d = shift_d[0];
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    div_cnt_d = '0;
                    state_d   = StIdle;
                    sout_d    = 1'b1;
                    sact_d    = 1'b0;
                    ready_d   = 1'b1;
                    done_d    = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            sout_q    <= 1'b1;
            sact_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            sout_q    <= sout_d;
            sact_q    <= sact_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign ready_o = ready_q;
    assign sout_o  = sout_q;
    assign sact_o  = sact_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: one instance with DIV=2 and one with DIV=1, WIDTH=4.
// Drivers push expected frames into a queue; a monitor rebuilds each frame
// from the serial line and compares it against a frame model.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic [1:0] rst_n;
    logic [1:0] en;
    logic [3:0] d_v [2];
    logic [1:0] ready_w, sout_w, sact_w, done_w;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_on   = 1'b0;

    typedef struct {
        int         dut;
        logic [3:0] word;
        int         start_cyc;
    } exp_t;

    exp_t exp_q [$];
    bit   abort_next [2];
    int   done_cnt [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_tx #(.WIDTH(4), .DIV(2)) u_dut_a (
        .clk_i   (clk),
        .rst_ni  (rst_n[0]),
        .en_i    (en[0]),
        .d_i     (d_v[0]),
        .ready_o (ready_w[0]),
        .sout_o  (sout_w[0]),
        .sact_o  (sact_w[0]),
        .done_o  (done_w[0])
    );

    serial_tx #(.WIDTH(4), .DIV(1)) u_dut_b (
        .clk_i   (clk),
        .rst_ni  (rst_n[1]),
        .en_i    (en[1]),
        .d_i     (d_v[1]),
        .ready_o (ready_w[1]),
        .sout_o  (sout_w[1]),
        .sact_o  (sact_w[1]),
        .done_o  (done_w[1])
    );

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    function automatic int div_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    // Frame model: slot 0 is the start bit, slots 1..4 the data LSB first,
    // slot 5 the stop bit; every slot lasts div samples.
    function automatic logic exp_bit(input logic [3:0] w, input int div, input int idx);
        int slot;
        slot = idx / div;
        if (slot == 0) return 1'b0;
        if (slot >= 5) return 1'b1;
        return w[slot-1];
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    logic [63:0] cap [2];
    int          len [2];
    bit          prev [2];

    always @(negedge clk) begin
        if (mon_on) begin
            for (int k = 0; k < 2; k++) begin
                if (done_w[k]) done_cnt[k]++;
                if (sact_w[k]) begin
                    if (!prev[k]) begin
                        if (exp_q.size() == 0 || exp_q[0].dut != k) begin
                            check(1'b0, "unexpected_frame", k, -1);
                        end else begin
                            check(cyc == exp_q[0].start_cyc, "start_cycle", cyc,
                                  exp_q[0].start_cyc);
                        end
                    end
                    if (len[k] < 64) cap[k][len[k]] = sout_w[k];
                    len[k]++;
                    check(ready_w[k] == 1'b0, "ready_busy", int'(ready_w[k]), 0);
                    check(done_w[k] == 1'b0, "done_busy", int'(done_w[k]), 0);
                end else if (prev[k]) begin
                    int   full;
                    int   n;
                    bit   bad;
                    exp_t e;
                    logic [63:0] ev;
                    logic [3:0]  rw;
                    full = 6 * div_of(k);
                    check(sout_w[k] == 1'b1, "sout_after_frame", int'(sout_w[k]), 1);
                    check(ready_w[k] == 1'b1, "ready_after_frame", int'(ready_w[k]), 1);
                    if (exp_q.size() == 0 || exp_q[0].dut != k) begin
                        check(1'b0, "frame_without_load", len[k], 0);
                    end else begin
                        e = exp_q.pop_front();
                        n = (len[k] < 64) ? len[k] : 64;
                        bad = 1'b0;
                        ev = '0;
                        for (int i = 0; i < n; i++) begin
                            ev[i] = exp_bit(e.word, div_of(k), i);
                            if (cap[k][i] !== ev[i]) bad = 1'b1;
                        end
                        check(!bad, "frame_bits", int'(cap[k][31:0]), int'(ev[31:0]));
                        if (abort_next[k]) begin
                            abort_next[k] = 1'b0;
                            check(done_w[k] == 1'b0, "done_on_abort", int'(done_w[k]), 0);
                            check(len[k] < full, "abort_len", len[k], full - 1);
                        end else begin
                            check(done_w[k] == 1'b1, "done_pulse", int'(done_w[k]), 1);
                            check(len[k] == full, "frame_len", len[k], full);
                            for (int j = 0; j < 4; j++) rw[j] = cap[k][(j + 1) * div_of(k)];
                            check(rw == e.word, "word_rebuilt", int'(rw), int'(e.word));
                        end
                    end
                    len[k] = 0;
                end else begin
                    check(done_w[k] == 1'b0, "done_idle", int'(done_w[k]), 0);
                    check(sout_w[k] == 1'b1, "sout_idle", int'(sout_w[k]), 1);
                end
                prev[k] = sact_w[k];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int k);
        int n;
        n = 0;
        while (!ready_w[k] && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check(1'b0, "ready_timeout", k, 1);
    endtask

    task automatic wait_done(input int k);
        int n;
        n = 0;
        while (!done_w[k] && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check(1'b0, "done_timeout", k, 1);
    endtask

    // Issue one load and record the frame it should produce.
    task automatic send(input int k, input logic [3:0] w);
        exp_t e;
        wait_ready(k);
        d_v[k] = w;
        en[k]  = 1'b1;
        tick();
        en[k]  = 1'b0;
        e.dut = k;
        e.word = w;
        e.start_cyc = cyc;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        rst_n  = 2'b00;
        en     = 2'b00;
        d_v[0] = 4'h0;
        d_v[1] = 4'h0;
        for (int k = 0; k < 2; k++) begin
            len[k] = 0; prev[k] = 1'b0; abort_next[k] = 1'b0; done_cnt[k] = 0;
        end
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            check(ready_w[k] == 1'b1, "reset_ready", int'(ready_w[k]), 1);
            check(sout_w[k] == 1'b1, "reset_sout", int'(sout_w[k]), 1);
            check(sact_w[k] == 1'b0, "reset_sact", int'(sact_w[k]), 0);
            check(done_w[k] == 1'b0, "reset_done", int'(done_w[k]), 0);
        end
        rst_n  = 2'b11;
        mon_on = 1'b1;
        repeat (2) tick();

        // Single frame 1011 with a rejected load mid-frame.
        send(0, 4'b1011);
        repeat (4) tick();
        d_v[0] = 4'b0000;
        en[0]  = 1'b1;
        tick();
        en[0]  = 1'b0;
        wait_done(0);
        repeat (6) tick();

        // Back-to-back: EN held, D switched to A in the DONE cycle.
        wait_ready(0);
        d_v[0] = 4'h5;
        en[0]  = 1'b1;
        tick();
        e.dut = 0; e.word = 4'h5; e.start_cyc = cyc;
        exp_q.push_back(e);
        wait_done(0);
        d_v[0] = 4'hA;
        tick();
        e.dut = 0; e.word = 4'hA; e.start_cyc = cyc;
        exp_q.push_back(e);
        en[0] = 1'b0;
        wait_done(0);
        repeat (4) tick();

        // Reset during data bit 2, then a clean frame.
        send(0, 4'h9);
        repeat (6) tick();
        abort_next[0] = 1'b1;
        rst_n[0] = 1'b0;
        tick();
        rst_n[0] = 1'b1;
        check(sout_w[0] == 1'b1, "abort_sout", int'(sout_w[0]), 1);
        check(sact_w[0] == 1'b0, "abort_sact", int'(sact_w[0]), 0);
        check(ready_w[0] == 1'b1, "abort_ready", int'(ready_w[0]), 1);
        check(done_w[0] == 1'b0, "abort_done", int'(done_w[0]), 0);
        tick();
        send(0, 4'h3);
        wait_done(0);
        repeat (4) tick();

        // Reset and EN on the same edge: no frame may start.
        d_v[0]   = 4'hF;
        en[0]    = 1'b1;
        rst_n[0] = 1'b0;
        tick();
        rst_n[0] = 1'b1;
        en[0]    = 1'b0;
        check(ready_w[0] == 1'b1, "collide_ready", int'(ready_w[0]), 1);
        check(sout_w[0] == 1'b1, "collide_sout", int'(sout_w[0]), 1);
        check(sact_w[0] == 1'b0, "collide_sact", int'(sact_w[0]), 0);
        repeat (8) tick();

        // DIV=1 sweep of every word, each loaded as soon as READY returns.
        for (int v = 0; v < 16; v++) send(1, 4'(v));
        wait_done(1);
        repeat (4) tick();

        // A few random words on the DIV=2 instance with random gaps.
        for (int i = 0; i < 6; i++) begin
            send(0, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 20)) tick();
        end
        wait_done(0);
        repeat (6) tick();

        check(exp_q.size() == 0, "frames_outstanding", exp_q.size(), 0);
        check(done_cnt[0] == 10, "done_count_a", done_cnt[0], 10);
        check(done_cnt[1] == 16, "done_count_b", done_cnt[1], 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
